// File: rtl/shift_pkg.sv
// Shared op encoding and elaboration helpers for the pipelined shifter.
package shift_pkg;

  localparam logic [2:0] OP_SLL      = 3'd0;
  localparam logic [2:0] OP_SRL      = 3'd1;
  localparam logic [2:0] OP_SRA      = 3'd2;
  localparam logic [2:0] OP_ROL      = 3'd3;
  localparam logic [2:0] OP_ROR      = 3'd4;
  localparam logic [2:0] OP_PASS_MIN = 3'd5;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Number of register stages needed to cover all shifter levels.
  function automatic int unsigned nreg_calc(input int unsigned saw, input int unsigned lps);
    return (saw + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One level of the logarithmic shifter: shift or rotate by 2^K when enabled.
module shift_level
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0
) (
  input  logic [WIDTH-1:0] src,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned SH  = 1 << K;
  localparam int unsigned RSH = WIDTH - SH;

  // Select the shifted or rotated form; pass-through ops and disabled levels forward src.
  always_comb begin
    result_c = src;
    if (en && (op < OP_PASS_MIN)) begin
      case (op)
        OP_SLL:  result_c = src << SH;
        OP_SRL:  result_c = src >> SH;
        OP_SRA:  result_c = (src >> SH) | ({WIDTH{sign}} << RSH);
        OP_ROL:  result_c = (src << SH) | (src >> RSH);
        OP_ROR:  result_c = (src >> SH) | (src << RSH);
        default: result_c = src;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready handshake, global stall and flush.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 4,
  localparam int unsigned SAW             = clog2(WIDTH),
  localparam int unsigned NREG            = nreg_calc(SAW, LEVELS_PER_STAGE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SAW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic             advance;
  logic             in_carry_c;
  logic             last_carry_c;
  logic [SAW-1:0]   sll_idx;
  logic [SAW-1:0]   srl_idx;

  // Stage inputs: stage 0 sees the ports, later stages see the previous register.
  logic [WIDTH-1:0] st_data  [NREG];
  logic [2:0]       st_op    [NREG];
  logic [SAW-1:0]   st_amt   [NREG];
  logic [TAG_W-1:0] st_tag   [NREG];
  logic [NREG-1:0]  st_sign;
  logic [NREG-1:0]  st_carry;
  logic [NREG-1:0]  st_valid;
  logic [WIDTH-1:0] res      [NREG];

  logic [WIDTH-1:0] data_q   [NREG];
  logic [2:0]       op_q     [NREG];
  logic [SAW-1:0]   amt_q    [NREG];
  logic [TAG_W-1:0] tag_q    [NREG];
  logic [NREG-1:0]  sign_q;
  logic [NREG-1:0]  carry_q;
  logic [NREG-1:0]  valid_q;
  logic             zero_q;

  assign advance  = !valid_q[NREG-1] || out_ready;
  assign in_ready = advance && !flush;

  // Carry for the linear shifts depends only on the original operand.
  always_comb begin
    in_carry_c = 1'b0;
    sll_idx    = -in_amt;
    srl_idx    = in_amt - SAW'(1);
    if (in_amt != '0) begin
      case (in_op)
        OP_SLL:         in_carry_c = in_data[sll_idx];
        OP_SRL, OP_SRA: in_carry_c = in_data[srl_idx];
        default:        in_carry_c = 1'b0;
      endcase
    end
  end

  // Route ports or previous stage registers into each stage.
  always_comb begin
    st_data[0]  = in_data;
    st_op[0]    = in_op;
    st_amt[0]   = in_amt;
    st_tag[0]   = in_tag;
    st_sign[0]  = in_data[WIDTH-1];
    st_carry[0] = in_carry_c;
    st_valid[0] = in_valid && in_ready;
    for (int unsigned s = 1; s < NREG; s++) begin
      st_data[s]  = data_q[s-1];
      st_op[s]    = op_q[s-1];
      st_amt[s]   = amt_q[s-1];
      st_tag[s]   = tag_q[s-1];
      st_sign[s]  = sign_q[s-1];
      st_carry[s] = carry_q[s-1];
      st_valid[s] = valid_q[s-1];
    end
  end

  // Level chain; each stage's last level output is that stage's result.
  for (genvar k = 0; k < SAW; k++) begin : g_lvl
    localparam int unsigned S = k / LEVELS_PER_STAGE;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;

    if ((k % LEVELS_PER_STAGE) == 0) begin : g_head
      assign src = st_data[S];
    end else begin : g_link
      assign src = g_lvl[k-1].dst;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_level (
      .src      (src),
      .en       (st_amt[S][k]),
      .op       (st_op[S]),
      .sign     (st_sign[S]),
      .result_c (dst)
    );

    if (((k % LEVELS_PER_STAGE) == (LEVELS_PER_STAGE - 1)) || (k == SAW - 1)) begin : g_tail
      assign res[S] = dst;
    end
  end

  // Rotations report the bit that wrapped, visible only once the result is complete.
  always_comb begin
    last_carry_c = st_carry[NREG-1];
    if (st_amt[NREG-1] != '0) begin
      if (st_op[NREG-1] == OP_ROL) begin
        last_carry_c = res[NREG-1][0];
      end else if (st_op[NREG-1] == OP_ROR) begin
        last_carry_c = res[NREG-1][WIDTH-1];
      end
    end
  end

  // Stage registers: all advance together, hold on stall, valids cleared on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NREG; s++) begin
        data_q[s]  <= '0;
        op_q[s]    <= '0;
        amt_q[s]   <= '0;
        tag_q[s]   <= '0;
        sign_q[s]  <= 1'b0;
        carry_q[s] <= 1'b0;
        valid_q[s] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (flush) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      for (int unsigned s = 0; s < NREG; s++) begin
        data_q[s]  <= res[s];
        op_q[s]    <= st_op[s];
        amt_q[s]   <= st_amt[s];
        tag_q[s]   <= st_tag[s];
        sign_q[s]  <= st_sign[s];
        carry_q[s] <= (s == NREG - 1) ? last_carry_c : st_carry[s];
        valid_q[s] <= st_valid[s];
      end
      zero_q <= st_valid[NREG-1] && (res[NREG-1] == '0);
    end
  end

  assign out_valid = valid_q[NREG-1];
  assign out_data  = data_q[NREG-1];
  assign out_carry = carry_q[NREG-1];
  assign out_tag   = tag_q[NREG-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Randomized and directed bench for shift_pipe with a queue-based scoreboard.
module tb_shift_pipe;

  localparam int NREG = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic [3:0]  out_tag;

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [7:0]  n_in_data = '0;
  logic [2:0]  n_in_amt = '0;
  logic [2:0]  n_in_op = '0;
  logic [3:0]  n_in_tag = '0;
  logic        n_out_valid;
  logic [7:0]  n_out_data;
  logic        n_out_carry;
  logic        n_out_zero;
  logic [3:0]  n_out_tag;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] pend_d  = '0;
  logic        pend_c  = 1'b0;
  bit          lat_chk = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_tag;
  logic        hold_c;

  shift_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  shift_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .in_amt(n_in_amt), .in_op(n_in_op), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(1'b1), .out_data(n_out_data),
    .out_carry(n_out_carry), .out_zero(n_out_zero), .out_tag(n_out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: shift semantics written directly from the operation definitions.
  function automatic void ref_op(input int w, input logic [2:0] op, input int amt,
                                 input logic [63:0] din, output logic [63:0] r, output logic c);
    logic [63:0] m;
    logic [63:0] d;
    logic        sg;
    m  = (64'd1 << w) - 64'd1;
    d  = din & m;
    sg = d[w-1];
    r  = d;
    c  = 1'b0;
    case (op)
      3'd0: begin r = (d << amt) & m;  if (amt != 0) c = (d >> (w - amt)) & 64'd1; end
      3'd1: begin r = d >> amt;        if (amt != 0) c = (d >> (amt - 1)) & 64'd1; end
      3'd2: begin
        r = (d >> amt) | (sg ? (m & ~(m >> amt)) : 64'd0);
        if (amt != 0) c = (d >> (amt - 1)) & 64'd1;
      end
      3'd3: begin r = ((d << amt) | (d >> (w - amt))) & m; if (amt != 0) c = r[0]; end
      3'd4: begin r = ((d >> amt) | (d << (w - amt))) & m; if (amt != 0) c = r[w-1]; end
      default: begin r = d; c = 1'b0; end
    endcase
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready) && !flush);
      if (!out_valid) check("zero_idle", out_zero, 1'b0);
      if (out_valid && !out_ready) begin
        if (stall_prev) begin
          check("hold_data", out_data, hold_d);
          check("hold_tag", out_tag, hold_tag);
          check("hold_carry", out_carry, hold_c);
        end
        stall_prev = 1'b1;
        hold_d = out_data; hold_tag = out_tag; hold_c = out_carry;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("data", out_data, e.d);
          check("carry", out_carry, e.c);
          check("zero", out_zero, e.d == 32'd0);
          check("tag", out_tag, e.tag);
          if (e.lat) check("latency", 64'(cyc - e.cyc), NREG);
        end
      end
      if (flush) begin
        q.delete();
        stall_prev = 1'b0;
      end else if (in_valid && in_ready) begin
        q.push_back('{d: pend_d, c: pend_c, tag: in_tag, cyc: cyc, lat: lat_chk});
      end
    end
  end

  // Present one op and hold it until accepted; entered just after a rising edge.
  task automatic send(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d,
                      input logic [3:0] tag, input logic [31:0] ed, input logic ec);
    bit acc;
    int n;
    in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d; in_tag = tag;
    pend_d = ed; pend_c = ec;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_rand();
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] d;
    logic [63:0] r;
    logic        c;
    op  = 3'($urandom_range(0, 7));
    amt = 5'($urandom);
    d   = $urandom;
    ref_op(32, op, int'(amt), 64'(d), r, c);
    send(op, amt, d, 4'($urandom), r[31:0], c);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // One isolated op through the 8-bit, one-level-per-stage instance.
  task automatic w8_run(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d,
                        input logic [3:0] tag, input logic [7:0] ed, input logic ec);
    int t0;
    int n;
    n_in_valid = 1'b1; n_in_op = op; n_in_amt = amt; n_in_data = d; n_in_tag = tag;
    @(negedge clk);
    check("w8_in_ready", n_in_ready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!n_out_valid && n < 20);
    check("w8_valid", n_out_valid, 1'b1);
    check("w8_data", n_out_data, ed);
    check("w8_carry", n_out_carry, ec);
    check("w8_zero", n_out_zero, ed == 8'd0);
    check("w8_tag", n_out_tag, tag);
    check("w8_latency", 64'(cyc - t0), NREG);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] r;
    logic        c;
    logic [2:0]  op8;
    logic [2:0]  amt8;
    logic [7:0]  d8;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'd0);
    check("rst_carry", out_carry, 1'b0);
    check("rst_tag", out_tag, 4'd0);
    check("rst_zero", out_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back directed ops on FF0000FF.
    lat_chk = 1'b1;
    send(3'b010, 5'd4, 32'hFF0000FF, 4'd1, 32'hFFF0000F, 1'b1);
    send(3'b001, 5'd4, 32'hFF0000FF, 4'd2, 32'h0FF0000F, 1'b1);
    send(3'b000, 5'd4, 32'hFF0000FF, 4'd3, 32'hF0000FF0, 1'b1);
    send(3'b011, 5'd4, 32'hFF0000FF, 4'd4, 32'hF0000FFF, 1'b1);
    send(3'b100, 5'd8, 32'hFF0000FF, 4'd5, 32'hFFFF0000, 1'b1);
    idle();
    drain();

    // Boundary amounts.
    send(3'b010, 5'd31, 32'hFF0000FF, 4'd6, 32'hFFFFFFFF, 1'b1);
    send(3'b001, 5'd31, 32'hFF0000FF, 4'd7, 32'h00000001, 1'b1);
    send(3'b000, 5'd31, 32'hFF0000FF, 4'd8, 32'h80000000, 1'b1);
    send(3'b001, 5'd16, 32'hFF0000FF, 4'd9, 32'h0000FF00, 1'b0);
    for (int o = 0; o < 8; o++) send(3'(o), 5'd0, 32'hFF0000FF, 4'(o), 32'hFF0000FF, 1'b0);
    send(3'b001, 5'd8, 32'h000000FF, 4'hA, 32'h00000000, 1'b1);
    // Pass-through ops ignore the amount.
    send(3'b111, 5'd9, 32'h12345678, 4'hB, 32'h12345678, 1'b0);
    send(3'b101, 5'd3, 32'h12345678, 4'hC, 32'h12345678, 1'b0);
    idle();
    drain();

    // Backpressure in the middle of a burst.
    lat_chk = 1'b0;
    fork
      begin
        repeat (5) send_rand();
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with three ops in flight and an op offered in the flush cycle.
    out_ready = 1'b0;
    repeat (3) send_rand();
    in_valid = 1'b1; in_op = 3'b001; in_amt = 5'd1; in_data = 32'h55; in_tag = 4'hF;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("flush_quiet", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(3'b001, 5'd4, 32'hFF0000FF, 4'h6, 32'h0FF0000F, 1'b1);
    idle();
    drain();

    // Reset in the middle of a stream.
    lat_chk = 1'b0;
    repeat (3) send_rand();
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_carry", out_carry, 1'b0);
    check("midrst_tag", out_tag, 4'd0);
    check("midrst_zero", out_zero, 1'b0);
    @(posedge clk); #1;
    lat_chk = 1'b1;
    repeat (3) send_rand();
    idle();
    drain();

    // Random traffic with random backpressure and occasional flush.
    lat_chk = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 4) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      if (($urandom % 40) == 0) begin
        idle();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      send_rand();
    end
    idle();
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Narrow configuration: one level per register stage.
    w8_run(3'b010, 3'd3, 8'h90, 4'h9, 8'hF2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op8  = 3'($urandom_range(0, 7));
      amt8 = 3'($urandom);
      d8   = 8'($urandom);
      ref_op(8, op8, int'(amt8), 64'(d8), r, c);
      w8_run(op8, amt8, d8, 4'(i), r[7:0], c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
